// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer and the pipeline registers.
//   - Sequencer state encoding (legacy-compatible 2-bit constants).
//   - Default register-index width.
//   - Bit indices of the per-stage enable bundle, plus the flush bundle type.
package pipe_ctrl_pkg;

  localparam int unsigned RegAwDefault = 5;

  // Sequencer states
  localparam logic [1:0] StRun    = 2'd0;
  localparam logic [1:0] StFreeze = 2'd1;
  localparam logic [1:0] StErr    = 2'd2;

  // Stage-enable bundle indices
  localparam int unsigned StgPc    = 0;
  localparam int unsigned StgIfId  = 1;
  localparam int unsigned StgIdEx  = 2;
  localparam int unsigned StgExMem = 3;
  localparam int unsigned StgMemWb = 4;
  localparam int unsigned NumStg   = 5;

  typedef logic [NumStg-1:0] stage_en_t;

  localparam stage_en_t StgAllEn  = '1;
  localparam stage_en_t StgNoneEn = '0;

  typedef struct packed {
    logic if_id;
    logic id_ex;
  } stage_flush_t;

  // Load-use bubble: hold PC and IF/ID, let ID/EX onward advance.
  function automatic stage_en_t ldu_stall_en();
    stage_en_t en;
    en          = StgAllEn;
    en[StgPc]   = 1'b0;
    en[StgIfId] = 1'b0;
    return en;
  endfunction

endpackage

// File: rtl/hz_ldu_detect.sv
// Load-use hazard detector (combinational). Shared with the forwarding unit.
// Flags when the instruction in EX is a load writing a non-zero rd that the
// instruction in ID reads through rs1 or rs2.
// Ports:
//   id_rs1_i, id_rs2_i         source indices of the ID instruction
//   id_use_rs1_i, id_use_rs2_i ID instruction actually reads rs1 / rs2
//   ex_rd_i                    destination index of the EX instruction
//   ex_memr_i, ex_regwen_i     EX instruction is a load / writes rd
//   ldu_o                      load-use hazard present
module hz_ldu_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_memr_i,
  input  logic              ex_regwen_i,
  output logic              ldu_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_use_rs2_i && (id_rs2_i == ex_rd_i);

  // x0 is never a real dependency
  assign ldu_o = ex_memr_i && ex_regwen_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
// Generates per-stage enables and flushes for load-use bubbles, taken-branch
// flushes and data-memory freezes; a watchdog latches a sticky error when memory
// stays busy too long. Outputs are combinational from state and inputs.
// Optional build macro HAZ_PERF_EN adds three saturating performance counters;
// without it the perf ports are tied to zero.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_rs1_i/id_rs2_i, id_use_* ID instruction sources
//   ex_rd_i, ex_memr_i, ex_regwen_i  EX instruction destination / load / write
//   ex_br_taken_i               EX resolved a taken branch/jump
//   mem_busy_i                  data memory not ready this cycle
//   pc_en_o, *_en_o             stage load enables
//   if_id_flush_o, id_ex_flush_o  stage flushes (load NOP/bubble)
//   hz_err_o                    sticky memory-timeout error
//   perf_stall_o/flush_o/freeze_o  event counters
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW      = RegAwDefault,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_TW      = 4,
  parameter int unsigned PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_memr_i,
  input  logic              ex_regwen_i,
  input  logic              ex_br_taken_i,
  input  logic              mem_busy_i,
  output logic              pc_en_o,
  output logic              if_id_en_o,
  output logic              if_id_flush_o,
  output logic              id_ex_en_o,
  output logic              id_ex_flush_o,
  output logic              ex_mem_en_o,
  output logic              mem_wb_en_o,
  output logic              hz_err_o,
  output logic [PERF_W-1:0] perf_stall_o,
  output logic [PERF_W-1:0] perf_flush_o,
  output logic [PERF_W-1:0] perf_freeze_o
);

  logic ldu;

  hz_ldu_detect #(
    .REG_AW(REG_AW)
  ) u_ldu_detect (
    .id_rs1_i    (id_rs1_i),
    .id_rs2_i    (id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i),
    .id_use_rs2_i(id_use_rs2_i),
    .ex_rd_i     (ex_rd_i),
    .ex_memr_i   (ex_memr_i),
    .ex_regwen_i (ex_regwen_i),
    .ldu_o       (ldu)
  );

  // ---------------------------------------------------------------------------
  // State and watchdog
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q, state_d;
  logic [CNT_TW-1:0] busy_cnt_q, busy_cnt_d;

  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    case (state_q)
      StRun: begin
        if (mem_busy_i) begin
          state_d    = StFreeze;
          busy_cnt_d = CNT_TW'(1);
        end
      end
      StFreeze: begin
        if (!mem_busy_i) begin
          state_d    = StRun;
          busy_cnt_d = '0;
        end else if (busy_cnt_q == CNT_TW'(MEM_TIMEOUT)) begin
          // This is busy cycle MEM_TIMEOUT+1
          state_d = StErr;
        end else begin
          busy_cnt_d = busy_cnt_q + CNT_TW'(1);
        end
      end
      StErr: begin
        state_d = StErr;
      end
      default: begin
        state_d    = StRun;
        busy_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode: ERR > busy freeze > branch flush > load-use > normal.
  // A deferred branch/ldu needs no memory: frozen registers keep its inputs up.
  // ---------------------------------------------------------------------------
  stage_en_t    stg_en;
  stage_flush_t stg_fl;
  logic         err;
  logic         ev_stall;
  logic         ev_flush;
  logic         ev_freeze;

  always_comb begin
    stg_en    = StgNoneEn;
    stg_fl    = '0;
    err       = 1'b0;
    ev_stall  = 1'b0;
    ev_flush  = 1'b0;
    ev_freeze = 1'b0;
    if (!rst_n) begin
      stg_en = StgNoneEn;
    end else if (state_q == StErr) begin
      err = 1'b1;
    end else if (mem_busy_i) begin
      ev_freeze = 1'b1;
    end else if (ex_br_taken_i) begin
      // The ldu victim in ID is squashed, so no bubble is needed
      stg_en       = StgAllEn;
      stg_fl.if_id = 1'b1;
      stg_fl.id_ex = 1'b1;
      ev_flush     = 1'b1;
    end else if (ldu) begin
      stg_en       = ldu_stall_en();
      stg_fl.id_ex = 1'b1;
      ev_stall     = 1'b1;
    end else begin
      stg_en = StgAllEn;
    end
  end

  assign pc_en_o       = stg_en[StgPc];
  assign if_id_en_o    = stg_en[StgIfId];
  assign id_ex_en_o    = stg_en[StgIdEx];
  assign ex_mem_en_o   = stg_en[StgExMem];
  assign mem_wb_en_o   = stg_en[StgMemWb];
  assign if_id_flush_o = stg_fl.if_id;
  assign id_ex_flush_o = stg_fl.id_ex;
  assign hz_err_o      = err;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef HAZ_PERF_EN
  logic [PERF_W-1:0] perf_stall_q, perf_flush_q, perf_freeze_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q  <= '0;
      perf_flush_q  <= '0;
      perf_freeze_q <= '0;
    end else begin
      if (ev_stall && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + PERF_W'(1);
      end
      if (ev_flush && (perf_flush_q != '1)) begin
        perf_flush_q <= perf_flush_q + PERF_W'(1);
      end
      if (ev_freeze && (perf_freeze_q != '1)) begin
        perf_freeze_q <= perf_freeze_q + PERF_W'(1);
      end
    end
  end

  assign perf_stall_o  = perf_stall_q;
  assign perf_flush_o  = perf_flush_q;
  assign perf_freeze_o = perf_freeze_q;
`else
  logic unused_perf_ev;
  assign unused_perf_ev = ^{ev_stall, ev_flush, ev_freeze};

  assign perf_stall_o  = '0;
  assign perf_flush_o  = '0;
  assign perf_freeze_o = '0;
`endif

endmodule
